// File: rtl/npu_cube_csa_resolve_if.sv
// npu_cube_csa_resolve_if: operand and result handshake bundle for npu_cube_csa_resolve.
//   in_valid/in_ready    : operand pair handshake (producer -> resolver)
//   in_sum/in_carry      : carry-save pair; carry bit i has weight 2^(i+1)
//   out_valid/out_ready  : result handshake (resolver -> consumer)
//   out_res/out_hi       : resolved value {out_hi, out_res}
//   out_sat              : result was saturated (optional feature)
// Modports: master = producer/consumer side, slave = resolver.
interface npu_cube_csa_resolve_if #(
    parameter int unsigned BITWIDTH = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_sum;
    logic [BITWIDTH-1:0] in_carry;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_res;
    logic [1:0]          out_hi;
    logic                out_sat;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_res, out_hi, out_sat
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_res, out_hi, out_sat
    );
endinterface

// File: rtl/npu_cube_csa_resolve.sv
// npu_cube_csa_resolve: chunk-serial resolution of a carry-save pair into binary,
// result = sum + (carry << 1), CHUNK bits per clock through a small adder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : npu_cube_csa_resolve_if.slave (operand/result handshakes and data)
//   busy       : high while an operation is in flight or its result is pending
// Optional feature: define NPU_CUBE_CSA_SAT_EN to saturate results that do not fit
// in BITWIDTH bits to all ones (out_hi = 0, out_sat = 1).
module npu_cube_csa_resolve #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned CHUNK    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    npu_cube_csa_resolve_if.slave   bus,
    output logic                    busy
);
    localparam int unsigned N  = BITWIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = CHUNK + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                c_q, c_d;
    logic [BITWIDTH-1:0] a_q, a_d;
    logic [BITWIDTH-1:0] b_q, b_d;
    logic                msb_q, msb_d;
    logic [BITWIDTH-1:0] res_q, res_d;
    logic [1:0]          hi_q, hi_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;

    logic [CHUNK-1:0]    a_chunk;
    logic [CHUNK-1:0]    b_chunk;
    logic [CW-1:0]       chunk_sum;
    logic [1:0]          hi_final;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum = CW'(a_chunk) + CW'(b_chunk) + CW'(c_q);
        // The carry vector's top bit has weight 2^BITWIDTH and lands straight in out_hi.
        hi_final  = 2'(msb_q) + 2'(chunk_sum[CHUNK]);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        msb_d   = msb_q;
        res_d   = res_q;
        hi_d    = hi_q;
        sat_d   = sat_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_sum;
                    b_d     = {bus.in_carry[BITWIDTH-2:0], 1'b0};
                    msb_d   = bus.in_carry[BITWIDTH-1];
                    c_d     = 1'b0;
                    k_d     = '0;
                    res_d   = '0;
                    hi_d    = '0;
                    sat_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (k_q == KW'(i)) begin
                        res_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                c_d = chunk_sum[CHUNK];
                if (k_q == KW'(N - 1)) begin
                    hi_d    = hi_final;
                    valid_d = 1'b1;
                    state_d = StDone;
`ifdef NPU_CUBE_CSA_SAT_EN
                    if (hi_final != 2'd0) begin
                        res_d = '1;
                        hi_d  = 2'd0;
                        sat_d = 1'b1;
                    end
`endif
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    k_d     = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            msb_q   <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            msb_q   <= msb_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_hi    = hi_q;
`ifdef NPU_CUBE_CSA_SAT_EN
    assign bus.out_sat   = sat_q;
`else
    assign bus.out_sat   = 1'b0;
`endif
    assign busy          = (state_q != StIdle);

`ifndef NPU_CUBE_CSA_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_q;
`endif
endmodule

// File: tb/tb_npu_cube_csa_resolve.sv
// Directed bench for npu_cube_csa_resolve (BITWIDTH=8, CHUNK=4).
module tb_npu_cube_csa_resolve;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   compared   = 0;
    int   mismatched = 0;

    npu_cube_csa_resolve_if #(.BITWIDTH(8)) bus ();

    npu_cube_csa_resolve #(
        .BITWIDTH(8),
        .CHUNK   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a pair for one edge, then withdraws it.
    task automatic issue(input logic [7:0] s, input logic [7:0] c);
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        bus.in_carry = c;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_edges);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_edges);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] res,
                                 input logic [1:0] hi, input logic sat);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_res"}, bus.out_res, res);
        check({tag, "_hi"}, bus.out_hi, hi);
        check({tag, "_sat"}, bus.out_sat, sat);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_res", bus.out_res, 8'h00);
        check("rst_out_hi", bus.out_hi, 2'd0);
        check("rst_out_sat", bus.out_sat, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Basic: 0x0F + (0x01 << 1) = 0x11
        bus.out_ready = 1'b1;
        issue(8'h0F, 8'h01);
        check("basic_busy", busy, 1'b1);
        check("basic_in_ready", bus.in_ready, 1'b0);
        check("basic_early_valid", bus.out_valid, 1'b0);
        wait_valid("basic", 2);
        expect_result("basic", 8'h11, 2'd0, 1'b0);
        step();
        check("basic_drain_valid", bus.out_valid, 1'b0);
        check("basic_drain_in_ready", bus.in_ready, 1'b1);

        // Cross-chunk carry: 0x08 + 0x08 = 0x10; inputs changed after capture are ignored
        issue(8'h08, 8'h04);
        bus.in_sum   = 8'hAA;
        bus.in_carry = 8'h55;
        wait_valid("cross", 2);
        expect_result("cross", 8'h10, 2'd0, 1'b0);
        step();

        // Maximum: 0xFF + 0x1FE = 0x2FD
        issue(8'hFF, 8'hFF);
        wait_valid("max", 2);
`ifdef NPU_CUBE_CSA_SAT_EN
        expect_result("max", 8'hFF, 2'd0, 1'b1);
`else
        expect_result("max", 8'hFD, 2'd2, 1'b0);
`endif
        step();

        // Backpressure: result held for 5 cycles
        bus.out_ready = 1'b0;
        issue(8'h0F, 8'h01);
        wait_valid("bp", 2);
        for (int i = 0; i < 5; i++) begin
            expect_result("bp_hold", 8'h11, 2'd0, 1'b0);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", bus.out_valid, 1'b0);
        check("bp_release_in_ready", bus.in_ready, 1'b1);
        check("bp_release_busy", busy, 1'b0);
        step();
        check("bp_single_transfer", bus.out_valid, 1'b0);

        // Back-to-back with in_valid held high
        bus.in_valid = 1'b1;
        bus.in_sum   = 8'h01;
        bus.in_carry = 8'h01;
        step();
        check("b2b_in_ready_after_capture", bus.in_ready, 1'b0);
        bus.in_sum   = 8'h10;
        bus.in_carry = 8'h08;
        wait_valid("b2b_first", 2);
        expect_result("b2b_first", 8'h03, 2'd0, 1'b0);
        step();
        check("b2b_gap_valid", bus.out_valid, 1'b0);
        check("b2b_gap_in_ready", bus.in_ready, 1'b1);
        step();
        check("b2b_second_capture", busy, 1'b1);
        bus.in_valid = 1'b0;
        wait_valid("b2b_second", 2);
        expect_result("b2b_second", 8'h20, 2'd0, 1'b0);
        step();
        check("b2b_no_dup_valid", bus.out_valid, 1'b0);
        step();
        check("b2b_no_dup_idle", busy, 1'b0);
        check("b2b_no_dup_valid2", bus.out_valid, 1'b0);

        // Reset mid-BUSY after the low chunk (0xF + 0x2 -> 0x1, carry 1) has been written
        issue(8'h0F, 8'h01);
        step();
        check("mid_partial_res", bus.out_res, 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_res", bus.out_res, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        step();
        step();
        check("mid_rst_hold_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        issue(8'h02, 8'h00);
        wait_valid("after_rst", 2);
        expect_result("after_rst", 8'h02, 2'd0, 1'b0);
        step();
        check("after_rst_drain", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
